adc_frame_feeder: RTL and testbench

ADC_FRAME_FEEDER -- requirements
Module: adc_frame_feeder

---
 rtl/adc_frame_feeder.sv | 150 +++++++++++++++
 tb/tb_adc_frame_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_feeder.sv
// ADC frame feeder: captures FRAME_LEN strobed ADC samples, then streams them to an FFT over AXI-Stream.
// Optional FEEDER_SIGNED_CONV_EN converts offset-binary samples to sign-extended two's complement.
module adc_frame_feeder #(
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned AUTO_PERIOD = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto_en,
    input  logic        sample_en,
    input  logic [9:0]  ad_data,
    input  logic        ad_otr,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_otr
);

    localparam int unsigned PW = $clog2(FRAME_LEN);
    localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

    state_t         state_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic           loaded_all_q;
    logic [TW-1:0]  timer_q;
    logic           pending_q;
    logic [15:0]    tdata_q;
    logic           tvalid_q;
    logic           tlast_q;
    logic           busy_q;
    logic           frame_done_q;
    logic           frame_otr_q;
    logic [9:0]     mem_q [FRAME_LEN];

    logic           timer_wrap_c;
    logic           enter_cap_c;
    logic           sample_wr_c;

    assign timer_wrap_c = auto_en && (timer_q == TW'(AUTO_PERIOD - 1));
    assign enter_cap_c  = (state_q == IDLE) && (start || (pending_q && auto_en));
    assign sample_wr_c  = (state_q == CAPTURE) && sample_en;

    function automatic logic [15:0] conv(input logic [9:0] d);
`ifdef FEEDER_SIGNED_CONV_EN
        logic [9:0] s;
        s = d ^ 10'h200;
        return {{6{s[9]}}, s};
`else
        return {6'b0, d};
`endif
    endfunction

    // Auto-trigger timer; a wrap while busy stays pending until the next capture starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else if (!auto_en) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_wrap_c ? '0 : timer_q + TW'(1);
            pending_q <= timer_wrap_c || (pending_q && !enter_cap_c);
        end
    end

    // Sample buffer, contents intentionally not reset
    always_ff @(posedge clk) begin
        if (sample_wr_c) begin
            mem_q[wr_ptr_q] <= ad_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            loaded_all_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_otr_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enter_cap_c) begin
                        state_q     <= CAPTURE;
                        wr_ptr_q    <= '0;
                        frame_otr_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (sample_en) begin
                        wr_ptr_q    <= wr_ptr_q + PW'(1);
                        frame_otr_q <= frame_otr_q | ad_otr;
                        if (wr_ptr_q == PW'(FRAME_LEN - 1)) begin
                            state_q      <= STREAM;
                            rd_ptr_q     <= '0;
                            loaded_all_q <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    // Output register refills whenever it is empty or its beat is being taken
                    if (tvalid_q && m_axis_tready && tlast_q) begin
                        tvalid_q     <= 1'b0;
                        tlast_q      <= 1'b0;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else if ((!tvalid_q || m_axis_tready) && !loaded_all_q) begin
                        tdata_q  <= conv(mem_q[rd_ptr_q]);
                        tvalid_q <= 1'b1;
                        tlast_q  <= (rd_ptr_q == PW'(FRAME_LEN - 1));
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        if (rd_ptr_q == PW'(FRAME_LEN - 1)) begin
                            loaded_all_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_otr     = frame_otr_q;

endmodule

// File: tb/tb_adc_frame_feeder.sv
// Directed bench for adc_frame_feeder (FRAME_LEN=16, AUTO_PERIOD=100): frame tables, stalls, reset, auto-trigger.
module tb_adc_frame_feeder;

    localparam int unsigned FLEN = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        auto_en;
    logic        sample_en;
    logic [9:0]  ad_data;
    logic        ad_otr;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        frame_done;
    logic        frame_otr;

    adc_frame_feeder #(.FRAME_LEN(FLEN), .AUTO_PERIOD(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .auto_en       (auto_en),
        .sample_en     (sample_en),
        .ad_data       (ad_data),
        .ad_otr        (ad_otr),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_otr     (frame_otr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  din;
        logic        otr;
        logic [15:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs [32];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] exp_conv(input logic [9:0] d);
`ifdef FEEDER_SIGNED_CONV_EN
        return {{7{~d[9]}}, d[8:0]};
`else
        return {6'b000000, d};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then feed the 16 table samples of one frame with the given spacing
    task automatic capture(input int base, input int gap);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("otr_cleared_on_start", frame_otr, 0);
        for (int i = 0; i < int'(FLEN); i++) begin
            sample_en = 1'b1;
            ad_data   = vecs[base + i].din;
            ad_otr    = vecs[base + i].otr;
            step();
            sample_en = 1'b0;
            ad_otr    = 1'b0;
            if (i < int'(FLEN) - 1) repeat (gap - 1) step();
        end
    endtask

    // Receive one frame; mode 0 = tready always 1, mode 1 = tready toggling. abort_at >= 0 stops at that beat.
    task automatic collect(input int base, input int mode, input int abort_at);
        int          beat    = 0;
        int          cyc     = 0;
        int          first_v = -1;
        int          bubbles = 0;
        int          dones   = 0;
        logic        stall   = 1'b0;
        logic [15:0] held_d  = '0;
        logic        held_l  = 1'b0;
        while (beat < int'(FLEN) && cyc < 300) begin
            if (abort_at >= 0 && beat == abort_at) return;
            m_axis_tready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            if (stall) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, held_d);
                check("stall_tlast", m_axis_tlast, held_l);
            end
            stall = 1'b0;
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (mode == 0 && beat > 0 && !m_axis_tvalid) bubbles++;
            if (frame_done) dones++;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("beat%0d_tdata", beat), m_axis_tdata, vecs[base + beat].exp_data);
                check($sformatf("beat%0d_tlast", beat), m_axis_tlast, vecs[base + beat].exp_last);
                beat++;
            end else if (m_axis_tvalid) begin
                stall  = 1'b1;
                held_d = m_axis_tdata;
                held_l = m_axis_tlast;
            end
            step();
            cyc++;
        end
        if (beat < int'(FLEN)) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d beats, expected %0d", beat, FLEN);
        end
        if (frame_done) dones++;
        check("tvalid_after_last", m_axis_tvalid, 0);
        check("frame_done_pulse", frame_done, 1);
        check("busy_after_frame", busy, 0);
        check("first_valid_latency_le2", (first_v >= 0 && first_v <= 2), 1);
        if (mode == 0) check("no_bubbles", bubbles, 0);
        m_axis_tready = 1'b1;
        step();
        if (frame_done) dones++;
        check("frame_done_count", dones, 1);
    endtask

    int rises [3];
    int nrise;
    int n;
    logic prev_busy;

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].din = 10'(i);
            vecs[i].otr = 1'b0;
        end
        vecs[16].din = 10'h000; vecs[17].din = 10'h200; vecs[18].din = 10'h3FF; vecs[19].din = 10'h155;
        vecs[20].din = 10'h2AA; vecs[21].din = 10'h001; vecs[22].din = 10'h1FF; vecs[23].din = 10'h0F0;
        vecs[24].din = 10'h300; vecs[25].din = 10'h100; vecs[26].din = 10'h3FE; vecs[27].din = 10'h201;
        vecs[28].din = 10'h080; vecs[29].din = 10'h37F; vecs[30].din = 10'h010; vecs[31].din = 10'h222;
        for (int i = 16; i < 32; i++) vecs[i].otr = (i == 16 + 7);
        for (int i = 0; i < 32; i++) begin
            vecs[i].exp_data = exp_conv(vecs[i].din);
            vecs[i].exp_last = (i % 16 == 15);
        end

        rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; sample_en = 1'b0;
        ad_data = '0; ad_otr = 1'b0; m_axis_tready = 1'b1;
        step();
        step();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_otr", frame_otr, 0);
        rst_n = 1'b1;

        // Samples in IDLE are ignored and nothing starts on its own
        sample_en = 1'b1; ad_data = 10'h3FF; ad_otr = 1'b1;
        repeat (5) step();
        sample_en = 1'b0; ad_otr = 1'b0;
        check("idle_no_start", busy, 0);

        capture(0, 4);
        collect(0, 0, -1);
        check("frameA_otr", frame_otr, 0);

        capture(0, 4);
        collect(0, 1, -1);

        capture(16, 1);
        collect(16, 0, -1);
        check("frameB_otr", frame_otr, 1);
        repeat (3) step();
        check("frameB_otr_held", frame_otr, 1);

        capture(0, 2);
        collect(0, 0, -1);
        check("frameC_otr_clean", frame_otr, 0);

        // Reset in the middle of STREAM
        capture(0, 1);
        collect(0, 0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tdata", m_axis_tdata, 0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("post_rst_idle", busy, 0);
        capture(0, 2);
        collect(0, 0, -1);

        // Auto-trigger every 100 cycles, wrap during a stalled STREAM is held pending
        auto_en = 1'b1; sample_en = 1'b1; ad_data = 10'h155; m_axis_tready = 1'b1;
        prev_busy = busy;
        nrise = 0;
        n = 0;
        while (nrise < 3 && n < 400) begin
            step();
            n++;
            if (busy && !prev_busy) begin
                rises[nrise] = n;
                nrise++;
            end
            prev_busy = busy;
        end
        check("auto_rise_count", nrise, 3);
        check("auto_first_capture", rises[0], 101);
        check("auto_period_1", rises[1] - rises[0], 100);
        check("auto_period_2", rises[2] - rises[1], 100);
        m_axis_tready = 1'b0;
        repeat (120) step();
        check("stall_over_wrap_busy", busy, 1);
        check("stall_over_wrap_tvalid", m_axis_tvalid, 1);
        m_axis_tready = 1'b1;
        n = 0;
        while (!frame_done && n < 60) begin
            step();
            n++;
        end
        check("pending_frame_done_seen", frame_done, 1);
        check("pending_idle_cycle", busy, 0);
        step();
        check("pending_restart", busy, 1);
        auto_en = 1'b0;
        n = 0;
        while (!frame_done && n < 80) begin
            step();
            n++;
        end
        check("last_auto_frame_done", frame_done, 1);
        sample_en = 1'b0;
        repeat (10) step();
        check("auto_off_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
